// File: rtl/preg_alloc_ctrl_pkg.sv
// Shared rename-stage types and defaults for the physical register allocator.
package rename_pkg;

  localparam int PREGWIDE_DEF = 7;
  localparam int PBUFDEEP_DEF = 2;
  localparam int RBUFDEEP_DEF = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    REFILL = 2'd2
  } alloc_state_e;

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/preg_alloc_ctrl_if.sv
// Rename/commit/freelist signal bundle seen by the physical register allocator.
import rename_pkg::*;

interface preg_alloc_ctrl_if #(
  parameter int PREGWIDE = PREGWIDE_DEF
);
  logic [1:0]          AllocReq;
  logic [1:0]          AllocGrant;
  logic [PREGWIDE-1:0] AllocPreg0;
  logic [PREGWIDE-1:0] AllocPreg1;
  logic [1:0]          ReleaseValid;
  logic [PREGWIDE-1:0] ReleasePreg0;
  logic [PREGWIDE-1:0] ReleasePreg1;
  logic                ReleaseReady;
  logic                FlushReq;
  logic                FlRable;
  logic [PREGWIDE-1:0] FlPreOut;
  logic                FlEmpty;
  logic                FlWable;
  logic [PREGWIDE-1:0] FlDin;
  logic                FlClean;
  logic                Busy;

  // Environment side: rename/commit stages plus the freelist storage.
  modport master (
    output AllocReq, ReleaseValid, ReleasePreg0, ReleasePreg1, FlushReq, FlPreOut, FlEmpty,
    input  AllocGrant, AllocPreg0, AllocPreg1, ReleaseReady, FlRable, FlWable, FlDin,
           FlClean, Busy
  );

  // Allocator side.
  modport slave (
    input  AllocReq, ReleaseValid, ReleasePreg0, ReleasePreg1, FlushReq, FlPreOut, FlEmpty,
    output AllocGrant, AllocPreg0, AllocPreg1, ReleaseReady, FlRable, FlWable, FlDin,
           FlClean, Busy
  );
endinterface

// File: rtl/preg_alloc_ctrl_rel_fifo.sv
// Release buffer: two pushes and one pop per cycle, with occupancy count.
// Caller guarantees no overflow (checks free space) and no underflow (count != 0).
module preg_rel_fifo
  import rename_pkg::*;
#(
  parameter  int WIDTH = PREGWIDE_DEF,
  parameter  int DEPTH = RBUFDEEP_DEF,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             Clk,
  input  logic             Rest,
  input  logic             clear,
  input  logic             push0,
  input  logic [WIDTH-1:0] din0,
  input  logic             push1,
  input  logic [WIDTH-1:0] din1,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wslot1;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // A lone slot1 release takes the next free entry, keeping the queue dense.
  assign wslot1 = push0 ? wrap_inc(wptr) : wptr;
  assign head   = mem[rptr];

  // Pointer and occupancy update; clear empties the queue without touching data.
  always_ff @(posedge Clk) begin
    if (Rest || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      case ({push1, push0})
        2'b00:   wptr <= wptr;
        2'b11:   wptr <= wrap_inc(wrap_inc(wptr));
        default: wptr <= wrap_inc(wptr);
      endcase
      if (pop) rptr <= wrap_inc(rptr);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  // Entry storage, slot0 ahead of slot1.
  always_ff @(posedge Clk) begin
    if (push0) mem[wptr] <= din0;
    if (push1) mem[wslot1] <= din1;
  end

endmodule

// File: rtl/preg_alloc_ctrl.sv
// Physical register allocator: prefetches freelist heads into a small buffer,
// grants them to rename slots, and funnels committed releases back to the freelist.
// PBUFDEEP must be at least 2 so both rename slots can be served in one cycle.
//
// state  | meaning
// RUN    | prefetch, grant, accept and drain releases
// FLUSH  | one-cycle freelist clean pulse, buffers cleared
// REFILL | freelist pointers settle, everything idle
module preg_alloc_ctrl
  import rename_pkg::*;
#(
  parameter int PREGWIDE = PREGWIDE_DEF,
  parameter int PBUFDEEP = PBUFDEEP_DEF,
  parameter int RBUFDEEP = RBUFDEEP_DEF
) (
  input logic              Clk,
  input logic              Rest,
  preg_alloc_ctrl_if.slave bus
);

  localparam int PCW = $clog2(PBUFDEEP + 1);
  localparam int RCW = $clog2(RBUFDEEP + 1);
  localparam int P1  = (PBUFDEEP > 1) ? 1 : 0;

  alloc_state_e        state;
  logic                busy_q;
  logic                clean_q;
  logic [PCW-1:0]      pcnt;
  logic [PREGWIDE-1:0] pbuf     [PBUFDEEP];
  logic [PREGWIDE-1:0] pbuf_nxt [PBUFDEEP];
  logic                run;
  logic                grant_ok;
  logic                rable;
  logic [1:0]          req_n;
  logic [1:0]          ngrant;
  int                  avail;
  logic [PREGWIDE-1:0] preg0;
  logic [PREGWIDE-1:0] preg1;
  logic [RCW-1:0]      rcnt;
  logic [PREGWIDE-1:0] rhead;
  logic                rel_ok;
  logic                push0;
  logic                push1;
  logic                drain;

  // Every output is gated by run/Rest so reset forces them low immediately.
  assign run      = (state == RUN) && !Rest;
  assign req_n    = popcnt2(bus.AllocReq);
  assign grant_ok = run && !bus.FlushReq && (int'(req_n) <= int'(pcnt));
  assign ngrant   = grant_ok ? req_n : 2'd0;
  assign avail    = int'(pcnt) - int'(ngrant);
  assign rable    = run && !bus.FlushReq && !bus.FlEmpty && (avail < PBUFDEEP);

  assign rel_ok = run && (int'(rcnt) + 2 <= RBUFDEEP);
  assign push0  = rel_ok && !bus.FlushReq && bus.ReleaseValid[0] && (bus.ReleasePreg0 != '0);
  assign push1  = rel_ok && !bus.FlushReq && bus.ReleaseValid[1] && (bus.ReleasePreg1 != '0);
  assign drain  = run && (rcnt != '0);

  // Oldest entry to the lowest requesting slot; tags come only from registered storage.
  always_comb begin
    preg0 = '0;
    preg1 = '0;
    if (grant_ok) begin
      if (bus.AllocReq[0]) begin
        preg0 = pbuf[0];
        if (bus.AllocReq[1]) preg1 = pbuf[P1];
      end else if (bus.AllocReq[1]) begin
        preg1 = pbuf[0];
      end
    end
  end

  // Shift out granted entries, then append the freelist head behind the survivors.
  always_comb begin
    for (int i = 0; i < PBUFDEEP; i++) begin
      pbuf_nxt[i] = pbuf[i];
      if (i + int'(ngrant) < PBUFDEEP) pbuf_nxt[i] = pbuf[i + int'(ngrant)];
    end
    if (rable) pbuf_nxt[avail] = bus.FlPreOut;
  end

  // Prefetch occupancy; a flush discards everything prefetched.
  always_ff @(posedge Clk) begin
    if (Rest || state == FLUSH) pcnt <= '0;
    else                        pcnt <= pcnt - PCW'(ngrant) + PCW'(rable);
  end

  // Prefetch entry storage.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < PBUFDEEP; i++) pbuf[i] <= pbuf_nxt[i];
  end

  // Flush sequencer; a flush request from any state restarts the sequence.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state   <= RUN;
      busy_q  <= 1'b0;
      clean_q <= 1'b0;
    end else if (bus.FlushReq) begin
      state   <= FLUSH;
      busy_q  <= 1'b1;
      clean_q <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          busy_q  <= 1'b0;
          clean_q <= 1'b0;
        end
        FLUSH: begin
          state   <= REFILL;
          busy_q  <= 1'b1;
          clean_q <= 1'b0;
        end
        REFILL: begin
          state   <= RUN;
          busy_q  <= 1'b0;
          clean_q <= 1'b0;
        end
        default: begin
          state   <= RUN;
          busy_q  <= 1'b0;
          clean_q <= 1'b0;
        end
      endcase
    end
  end

  preg_rel_fifo #(
    .WIDTH (PREGWIDE),
    .DEPTH (RBUFDEEP)
  ) u_rel_fifo (
    .Clk   (Clk),
    .Rest  (Rest),
    .clear (state == FLUSH),
    .push0 (push0),
    .din0  (bus.ReleasePreg0),
    .push1 (push1),
    .din1  (bus.ReleasePreg1),
    .pop   (drain),
    .head  (rhead),
    .count (rcnt)
  );

  assign bus.AllocGrant   = grant_ok ? bus.AllocReq : 2'b00;
  assign bus.AllocPreg0   = preg0;
  assign bus.AllocPreg1   = preg1;
  assign bus.ReleaseReady = rel_ok;
  assign bus.FlRable      = rable;
  assign bus.FlWable      = drain;
  assign bus.FlDin        = drain ? rhead : '0;
  assign bus.FlClean      = clean_q && !Rest;
  assign bus.Busy         = busy_q && !Rest;

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Directed vector bench for preg_alloc_ctrl with a counting freelist stub
// whose head sequence is 32, 36, 40, ... advancing on each pop.
module tb_preg_alloc_ctrl;
  import rename_pkg::*;

  localparam int PW = PREGWIDE_DEF;

  logic Clk = 1'b0;
  logic Rest;
  int   stub_k;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 Clk = ~Clk;

  preg_alloc_ctrl_if #(.PREGWIDE(PW)) bus ();

  preg_alloc_ctrl #(
    .PREGWIDE (PW),
    .PBUFDEEP (PBUFDEEP_DEF),
    .RBUFDEEP (RBUFDEEP_DEF)
  ) dut (
    .Clk  (Clk),
    .Rest (Rest),
    .bus  (bus)
  );

  always @(posedge Clk) begin
    if (Rest)             stub_k <= 0;
    else if (bus.FlRable) stub_k <= stub_k + 1;
  end
  assign bus.FlPreOut = PW'(32 + 4 * stub_k);

  typedef struct {
    logic [1:0] req;
    logic [1:0] rv;
    int         r0;
    int         r1;
    logic       flush;
    logic       empty;
    logic [1:0] gnt;
    int         p0;
    int         p1;
    logic       rrdy;
    logic       rable;
    logic       wable;
    int         din;
    logic       clean;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] req, input logic [1:0] rv, input int r0,
                              input int r1, input logic flush, input logic empty,
                              input logic [1:0] gnt, input int p0, input int p1,
                              input logic rrdy, input logic rable, input logic wable,
                              input int din, input logic clean, input logic busy);
    vec_t v;
    v.req = req; v.rv = rv; v.r0 = r0; v.r1 = r1; v.flush = flush; v.empty = empty;
    v.gnt = gnt; v.p0 = p0; v.p1 = p1; v.rrdy = rrdy; v.rable = rable; v.wable = wable;
    v.din = din; v.clean = clean; v.busy = busy;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.AllocReq     = v.req;
    bus.ReleaseValid = v.rv;
    bus.ReleasePreg0 = PW'(v.r0);
    bus.ReleasePreg1 = PW'(v.r1);
    bus.FlushReq     = v.flush;
    bus.FlEmpty      = v.empty;
  endtask

  task automatic cmp(input string tag, input string fld, input int got, input int want);
    if (got != want) begin
      n_miss++;
      $display("FAIL %s %s got %0d want %0d", tag, fld, got, want);
    end
  endtask

  task automatic check(input string tag, input vec_t v);
    n_vec++;
    cmp(tag, "AllocGrant",   int'(bus.AllocGrant),   int'(v.gnt));
    cmp(tag, "AllocPreg0",   int'(bus.AllocPreg0),   v.p0);
    cmp(tag, "AllocPreg1",   int'(bus.AllocPreg1),   v.p1);
    cmp(tag, "ReleaseReady", int'(bus.ReleaseReady), int'(v.rrdy));
    cmp(tag, "FlRable",      int'(bus.FlRable),      int'(v.rable));
    cmp(tag, "FlWable",      int'(bus.FlWable),      int'(v.wable));
    cmp(tag, "FlDin",        int'(bus.FlDin),        v.din);
    cmp(tag, "FlClean",      int'(bus.FlClean),      int'(v.clean));
    cmp(tag, "Busy",         int'(bus.Busy),         int'(v.busy));
  endtask

  // Apply at posedge+1, sample at posedge+4, leave at posedge+1 of the next cycle.
  task automatic step(input string tag, input vec_t v);
    drive(v);
    #3;
    check(tag, v);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          req    rv     r0  r1 fl    emp   | gnt  p0  p1 rrdy  rable wable din clean busy
    // prefetch fill and allocation
    tbl.push_back(mk(2'b00, 2'b00,  0,  0, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00,  0,  0, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00,  0,  0, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b0, 1'b0,  0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00,  0,  0, 1'b0, 1'b0, 2'b11, 32, 36, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00,  0,  0, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b10, 2'b00,  0,  0, 1'b0, 1'b0, 2'b10,  0, 40, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b01, 2'b00,  0,  0, 1'b0, 1'b0, 2'b01, 44,  0, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0));
    // release buffer: zero tag dropped, 2-in/1-out, full back-pressure drops offer
    tbl.push_back(mk(2'b00, 2'b11, 44,  0, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b0, 1'b0,  0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b11, 48, 52, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b0, 1'b1, 44, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b11, 56, 60, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b0, 1'b1, 48, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b11, 70, 72, 1'b0, 1'b0, 2'b00,  0,  0, 1'b0, 1'b0, 1'b1, 52, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00,  0,  0, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b0, 1'b1, 56, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00,  0,  0, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b0, 1'b1, 60, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b11,  0, 76, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b0, 1'b0,  0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b10,  5, 80, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b0, 1'b1, 76, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00,  0,  0, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b0, 1'b1, 80, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00,  0,  0, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b0, 1'b0,  0, 1'b0, 1'b0));
    // flush with competing alloc and release, then prefetch restart from an empty buffer
    tbl.push_back(mk(2'b11, 2'b11, 84, 88, 1'b1, 1'b0, 2'b00,  0,  0, 1'b1, 1'b0, 1'b0,  0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, 2'b11, 84, 88, 1'b0, 1'b0, 2'b00,  0,  0, 1'b0, 1'b0, 1'b0,  0, 1'b1, 1'b1));
    tbl.push_back(mk(2'b11, 2'b11, 84, 88, 1'b0, 1'b0, 2'b00,  0,  0, 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b1));
    tbl.push_back(mk(2'b01, 2'b00,  0,  0, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00,  0,  0, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b01, 2'b00,  0,  0, 1'b0, 1'b0, 2'b01, 56,  0, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0));
    // freelist empty stretch: no prefetch, no grants, resume one cycle after refill
    tbl.push_back(mk(2'b11, 2'b00,  0,  0, 1'b0, 1'b1, 2'b11, 60, 64, 1'b1, 1'b0, 1'b0,  0, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(2'b01, 2'b00, 0, 0, 1'b0, 1'b1, 2'b00, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b01, 2'b00,  0,  0, 1'b0, 1'b0, 2'b00,  0,  0, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b01, 2'b00,  0,  0, 1'b0, 1'b0, 2'b01, 68,  0, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0));

    // Reset held with live requests: every output must stay low.
    Rest = 1'b1;
    drive(mk(2'b11, 2'b11, 44, 48, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    repeat (2) @(posedge Clk);
    #1;
    #3;
    check("reset", mk(2'b11, 2'b11, 44, 48, 1'b0, 1'b0,
                      2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    @(posedge Clk);
    #1;
    Rest = 1'b0;

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // Reset landing in the FLUSH cycle aborts the sequence without a clean pulse.
    step("mrst_req",  mk(2'b00, 2'b00, 0, 0, 1'b1, 1'b0,
                         2'b00, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    Rest = 1'b1;
    step("mrst_hold", mk(2'b01, 2'b00, 0, 0, 1'b0, 1'b0,
                         2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    Rest = 1'b0;
    step("mrst_rel",  mk(2'b01, 2'b00, 0, 0, 1'b0, 1'b0,
                         2'b00, 0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0));
    step("mrst_gnt",  mk(2'b01, 2'b00, 0, 0, 1'b0, 1'b0,
                         2'b01, 32, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/preg_alloc_ctrl.md
PREG_ALLOC_CTRL -- requirements
Module: preg_alloc_ctrl

Interface
REQ-001 SHALL have parameter PREGWIDE, default 7: physical register tag width.
REQ-002 SHALL have parameter PBUFDEEP, default 2: prefetch buffer entries.
REQ-003 SHALL have parameter RBUFDEEP, default 4: release buffer entries.
REQ-004 Clk  in  1  sole clock, rising edge.
REQ-005 Rest  in  1  synchronous, active-high reset.
REQ-006 AllocReq  in  2  per rename slot: request one preg.
REQ-007 AllocGrant  out  2  per slot: grant, same cycle.
REQ-008 AllocPreg0 / AllocPreg1  out  PREGWIDE each  granted tags.
REQ-009 ReleaseValid  in  2  commit slots freeing a preg.
REQ-010 ReleasePreg0 / ReleasePreg1  in  PREGWIDE each  freed tags.
REQ-011 ReleaseReady  out  1  release buffer can accept 2.
REQ-012 FlushReq  in  1  pipeline flush, rebuild freelist.
REQ-013 FlRable  out  1  pop to freelist.
REQ-014 FlPreOut  in  PREGWIDE  freelist head, combinational.
REQ-015 FlEmpty  in  1  freelist empty.
REQ-016 FlWable  out  1  push to freelist.
REQ-017 FlDin  out  PREGWIDE  push data.
REQ-018 FlClean  out  1  freelist clean pulse.
REQ-019 Busy  out  1  flush sequence in progress.

Function
REQ-020 FSM states RUN, FLUSH, REFILL. RUN->FLUSH on FlushReq. FLUSH->REFILL unconditionally. REFILL->RUN unconditionally. FlushReq in any state->FLUSH next cycle.
REQ-021 In RUN, FlRable=1 iff !FlEmpty && (PbufCount - grants this cycle) < PBUFDEEP && !FlushReq. FlPreOut is captured into the prefetch buffer at that edge and is grantable from the next cycle.
REQ-022 Allocation is all-or-nothing. If popcount(AllocReq) <= PbufCount in RUN with no FlushReq, AllocGrant=AllocReq; otherwise AllocGrant=0.
REQ-023 The oldest prefetch entry goes to the lowest requesting slot. If both slots request, AllocPreg1 gets the second-oldest entry. Ungranted AllocPreg outputs are 0.
REQ-024 PbufCount next = PbufCount - grants + FlRable, range 0..PBUFDEEP, never wraps.
REQ-025 ReleaseReady=1 iff state RUN and release buffer free entries >= 2.
REQ-026 Releases are accepted only when ReleaseReady=1, enqueued slot0 then slot1. A tag equal to 0 is dropped (hardwired zero register).
REQ-027 In RUN, one release buffer entry drains per cycle: FlWable=1, FlDin=oldest entry. Push and pop to the freelist may occur in the same cycle.
REQ-028 Simultaneous enqueue of 2 and dequeue of 1 on the release buffer SHALL be handled correctly. Pointers wrap modulo RBUFDEEP.
REQ-029 In FLUSH: FlClean=1 for exactly one cycle. Prefetch and release buffers are cleared. AllocGrant, FlRable, FlWable and ReleaseReady are 0.
REQ-030 In REFILL, all outputs are inactive (freelist pointers settle). Prefetch resumes in RUN.
REQ-031 Busy=1 in FLUSH and REFILL, 0 in RUN.
REQ-032 FlushReq has priority over same-cycle alloc and release: grants are suppressed and offered releases are dropped.

Reset
REQ-033 While Rest=1: state is RUN, PbufCount=0, release buffer is empty, and all outputs are 0.
REQ-034 First cycle after Rest falls: ReleaseReady=1, AllocGrant=0, FlRable=!FlEmpty.
REQ-035 Rest asserted mid-flush aborts the sequence. No FlClean is issued by reset.

Structure
REQ-036 PREGWIDE, PBUFDEEP, RBUFDEEP defaults and the FSM state encoding SHALL live in shared package rename_pkg.
REQ-037 The release buffer SHALL be sub-module preg_rel_fifo (2-in/1-out, count output). The prefetch buffer and FSM stay inline.
REQ-038 No combinational path from FlPreOut to any AllocPreg output.

Verification
REQ-039 Freelist stub heads 32,36,40, no requests after reset -> FlRable=1 for cycles 1-2; PbufCount=2; FlRable=0 cycle 3.
REQ-040 PbufCount=2 (32,36), AllocReq=2'b11 -> AllocGrant=11, AllocPreg0=32, AllocPreg1=36; FlRable=1 same cycle.
REQ-041 PbufCount=1 (32), AllocReq=2'b11 -> AllocGrant=00. AllocReq=2'b10 -> AllocGrant=10, AllocPreg1=32.
REQ-042 ReleaseValid=11 with tags 44,0, then 48,52, then 56,60 -> FlDin sequence 44,48,52,56,60. Tag 0 never pushed. ReleaseReady falls when free < 2.
REQ-043 FlushReq with AllocReq=11 and ReleaseValid=11 -> AllocGrant=00, nothing enqueued, FlClean=1 next cycle only, Busy=1 for 2 cycles, then prefetch restarts.
REQ-044 FlEmpty=1 for 5 cycles with AllocReq=01 -> FlRable=0, AllocGrant=00 throughout. Grants resume 1 cycle after FlEmpty falls.
